// File: rtl/mem_stage.sv
// Memory pipeline stage: pass-through in 1 cycle, load/store over a req/ack bus, then one WB pulse.
// Optional MEM_TIMEOUT_EN aborts a bus wait after TIMEOUT cycles and flags bus_err.
module mem_stage #(
  parameter int DW      = 32,
  parameter int RW      = 4,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [DW-1:0] in_addr,
  input  logic [DW-1:0] in_wdata,
  input  logic [RW-1:0] in_rd,
  input  logic          in_rd_we,
  input  logic [DW-1:0] in_rd_val,
  output logic          bus_req,
  output logic          bus_we,
  output logic [DW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata,
  output logic          wb_valid,
  output logic          wb_we,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          bus_err
);

  typedef enum logic [1:0] {IDLE, BUS, WB} state_t;

  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          rd_we_q, rd_we_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [DW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic          wb_valid_q, wb_valid_d;
  logic          wb_we_q, wb_we_d;
  logic [RW-1:0] wb_rd_q, wb_rd_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          accept;
  logic          is_mem;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
`endif

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid & in_ready;
  assign is_mem   = (in_op == OP_LOAD) || (in_op == OP_STORE);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rd_we_d     = rd_we_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
`ifdef MEM_TIMEOUT_EN
    wait_d      = wait_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = in_op;
          rd_d    = in_rd;
          rd_we_d = in_rd_we;
          if (is_mem) begin
            state_d     = BUS;
            bus_req_d   = 1'b1;
            bus_we_d    = (in_op == OP_STORE);
            bus_addr_d  = in_addr;
            bus_wdata_d = (in_op == OP_STORE) ? in_wdata : '0;
`ifdef MEM_TIMEOUT_EN
            wait_d      = '0;
`endif
          end else begin
            wb_valid_d = 1'b1;
            wb_we_d    = in_rd_we;
            wb_rd_d    = in_rd;
            wb_data_d  = in_rd_val;
          end
        end
      end
      BUS: begin
        // An ack on the final allowed wait cycle takes priority over the abort.
        if (bus_ack) begin
          state_d    = WB;
          bus_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          if (op_q == OP_LOAD) begin
            wb_we_d   = rd_we_q;
            wb_data_d = bus_rdata;
          end else begin
            wb_we_d   = 1'b0;
            wb_data_d = '0;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (wait_q == CW'(TIMEOUT - 1)) begin
          state_d    = WB;
          bus_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_we_d    = 1'b0;
          wb_data_d  = DW'(32'hDEAD_BEEF);
          err_d      = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      WB: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      rd_we_q     <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
`ifdef MEM_TIMEOUT_EN
      wait_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      rd_we_q     <= rd_we_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
`ifdef MEM_TIMEOUT_EN
      wait_q      <= wait_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
`ifdef MEM_TIMEOUT_EN
  assign bus_err   = err_q;
`else
  assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboard of expected writebacks plus inline bus/handshake checks.
module tb_mem_stage;
  localparam int DW = 32;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [DW-1:0] in_addr, in_wdata, in_rd_val;
  logic [RW-1:0] in_rd;
  logic          in_rd_we;
  logic          bus_req, bus_we, bus_ack;
  logic [DW-1:0] bus_addr, bus_wdata, bus_rdata;
  logic          wb_valid, wb_we, bus_err;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;

  typedef struct packed {
    logic          we;
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
    logic          err;
  } wb_t;

  wb_t exp_q[$];
  wb_t got;
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  mem_stage #(.DW(DW), .RW(RW), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .in_rd_we(in_rd_we), .in_rd_val(in_rd_val),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [RW-1:0] rd, input logic [DW-1:0] data,
                      input logic err);
    wb_t e;
    e.we = we; e.rd = rd; e.data = data; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] op, input logic [DW-1:0] addr, input logic [DW-1:0] wd,
                       input logic [RW-1:0] rd, input logic we, input logic [DW-1:0] val);
    in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wd;
    in_rd = rd; in_rd_we = we; in_rd_val = val;
  endtask

  // Writeback monitor: every wb_valid pulse must match the oldest expected entry.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (wb_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", 1, 0);
        end else begin
          got = exp_q.pop_front();
          chk("wb_rd", wb_rd, got.rd);
          chk("wb_we", wb_we, got.we);
          chk("wb_data", wb_data, got.data);
          chk("wb_err", bus_err, got.err);
        end
      end else begin
        chk("wb_we_idle", wb_we, 0);
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_addr = '0; in_wdata = '0;
    in_rd = '0; in_rd_we = 1'b0; in_rd_val = '0; bus_ack = 1'b0; bus_rdata = '0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_bus_err", bus_err, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Pass-through stream; the last uses op 3, which must behave as pass-through.
    for (int i = 1; i <= 4; i++) begin
      drive((i == 4) ? 2'd3 : 2'd0, 32'h0, 32'h0, RW'(i), 1'b1, 32'h10 + DW'(i - 1));
      push(1'b1, RW'(i), 32'h10 + DW'(i - 1), 1'b0);
      chk("pt_in_ready", in_ready, 1);
      tick();
      chk("pt_wb_valid", wb_valid, 1);
      chk("pt_no_bus", bus_req, 0);
    end
    in_valid = 1'b0;
    tick();
    chk("pt_wb_end", wb_valid, 0);

    // Load with three wait states.
    drive(2'd1, 32'h40, 32'hFFFF_FFFF, 4'd5, 1'b1, 32'h0);
    push(1'b1, 4'd5, 32'hCAFE_0001, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("ld_bus_req", bus_req, 1);
      chk("ld_bus_we", bus_we, 0);
      chk("ld_bus_addr", bus_addr, 32'h40);
      chk("ld_bus_wdata", bus_wdata, 0);
      chk("ld_in_ready", in_ready, 0);
      if (c == 4) begin
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_0001;
      end
      tick();
      bus_ack = 1'b0; bus_rdata = '0;
    end
    chk("ld_req_drop", bus_req, 0);
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_ready", in_ready, 0);
    tick();
    chk("ld_idle_ready", in_ready, 1);

    // Zero-wait store.
    drive(2'd2, 32'h80, 32'h1234_5678, 4'd7, 1'b1, 32'h0);
    push(1'b0, 4'd7, 32'h0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("st_bus_req", bus_req, 1);
    chk("st_bus_we", bus_we, 1);
    chk("st_bus_addr", bus_addr, 32'h80);
    chk("st_bus_wdata", bus_wdata, 32'h1234_5678);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("st_req_drop", bus_req, 0);
    chk("st_wb_valid", wb_valid, 1);
    tick();
    chk("st_idle_ready", in_ready, 1);

    // Reset during the second BUS cycle drops the request; later ack is stray.
    drive(2'd1, 32'h44, 32'h0, 4'd9, 1'b1, 32'h0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("rb_bus_req", bus_req, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rb_req_drop", bus_req, 0);
    chk("rb_in_ready", in_ready, 1);
    chk("rb_wb_valid", wb_valid, 0);
    bus_ack = 1'b1; bus_rdata = 32'h0BAD;
    tick();
    bus_ack = 1'b0;
    chk("rb_stray_wb", wb_valid, 0);
    chk("rb_stray_req", bus_req, 0);

    // Spurious ack while idle, then an instruction held through a stall.
    bus_ack = 1'b1; bus_rdata = 32'h0BAD;
    tick();
    bus_ack = 1'b0; bus_rdata = '0;
    chk("sp_wb_valid", wb_valid, 0);
    chk("sp_wb_data", wb_data, 0);
    chk("sp_in_ready", in_ready, 1);
    drive(2'd1, 32'h10, 32'h0, 4'd3, 1'b1, 32'h0);
    push(1'b1, 4'd3, 32'h55, 1'b0);
    tick();
    drive(2'd0, 32'h0, 32'h0, 4'd4, 1'b1, 32'h99);
    push(1'b1, 4'd4, 32'h99, 1'b0);
    chk("hd_ready_bus1", in_ready, 0);
    tick();
    chk("hd_ready_bus2", in_ready, 0);
    chk("hd_no_wb", wb_valid, 0);
    bus_ack = 1'b1; bus_rdata = 32'h55;
    tick();
    bus_ack = 1'b0; bus_rdata = '0;
    chk("hd_ready_wb", in_ready, 0);
    tick();
    chk("hd_ready_back", in_ready, 1);
    chk("hd_not_yet", wb_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("hd_accepted", wb_valid, 1);
    tick();

`ifdef MEM_TIMEOUT_EN
    // Load with no ack: abort after four BUS cycles.
    drive(2'd1, 32'h20, 32'h0, 4'd6, 1'b1, 32'h0);
    push(1'b0, 4'd6, 32'hDEAD_BEEF, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("to_bus_req", bus_req, 1);
      tick();
    end
    chk("to_req_drop", bus_req, 0);
    chk("to_bus_err", bus_err, 1);
    tick();
    chk("to_err_pulse", bus_err, 0);
    // Ack on the fourth cycle wins over the timeout.
    drive(2'd1, 32'h20, 32'h0, 4'd6, 1'b1, 32'h0);
    push(1'b1, 4'd6, 32'hA5A5_A5A5, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("ta_bus_req", bus_req, 1);
      if (c == 4) begin
        bus_ack = 1'b1; bus_rdata = 32'hA5A5_A5A5;
      end
      tick();
      bus_ack = 1'b0;
    end
    chk("ta_bus_err", bus_err, 0);
    tick();
`endif

    tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes one executed instruction at a time and performs any data-memory load or store over a req/ack bus with variable wait states.
- Produces a single-cycle register-writeback pulse for the register file.
- Stalls the execute stage through in_ready while a bus transaction is outstanding.

Parameters:
- DW, 32, data and address width.
- RW, 4, register index width.
- TIMEOUT, 16, maximum bus wait cycles before abort (used only with the optional feature).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  execute stage presents an instruction.
- in_ready  output  1  stage can accept; high only in IDLE.
- in_op  input  2  0 = pass-through, 1 = load, 2 = store, 3 = treated as pass-through.
- in_addr  input  DW  memory word address (load/store).
- in_wdata  input  DW  store data.
- in_rd  input  RW  destination register index.
- in_rd_we  input  1  destination write enable.
- in_rd_val  input  DW  ALU result for pass-through.
- bus_req  output  1  bus request, held until ack.
- bus_we  output  1  1 = write, 0 = read.
- bus_addr  output  DW  bus address.
- bus_wdata  output  DW  bus write data.
- bus_ack  input  1  bus completion, one-cycle pulse.
- bus_rdata  input  DW  read data, valid when bus_ack = 1.
- wb_valid  output  1  writeback pulse.
- wb_we  output  1  register write enable.
- wb_rd  output  RW  register index.
- wb_data  output  DW  writeback data.
- bus_err  output  1  timeout error pulse (optional feature; tied 0 without it).

Behaviour:
- Reset values:
  - state = IDLE.
  - bus_req, bus_we, wb_valid, wb_we, bus_err = 0.
  - bus_addr, bus_wdata, wb_rd, wb_data = 0.
  - in_ready is combinational: 1 in IDLE.
- States: IDLE, BUS, WB.
- Accept: in_valid & in_ready at an edge latches in_op, in_addr, in_wdata, in_rd, in_rd_we and in_rd_val.
- IDLE, pass-through accepted:
  - Next cycle: wb_valid = 1, wb_we = in_rd_we, wb_rd = in_rd, wb_data = in_rd_val.
  - Stays IDLE, so back-to-back pass-throughs sustain 1 instruction/cycle at latency 1.
- IDLE, load/store accepted:
  - Next cycle: state = BUS, bus_req = 1, bus_we = (op == store), bus_addr = in_addr, bus_wdata = in_wdata (store) or 0 (load).
- BUS:
  - bus_req and bus_we/addr/wdata held stable every cycle until bus_ack is sampled 1.
  - On the ack edge: bus_req drops to 0 next cycle; load captures bus_rdata; state = WB.
  - Ack in the first BUS cycle is legal (zero wait states).
- WB, one cycle:
  - wb_valid = 1, wb_rd = latched rd.
  - Load: wb_we = latched rd_we, wb_data = captured rdata.
  - Store: wb_we = 0, wb_data = 0.
  - Next state = IDLE.
- Load/store latency: accept edge to wb_valid = 2 + wait cycles. Minimum throughput: one memory op per 3 cycles.
- wb_valid is a one-cycle pulse; no backpressure from writeback. wb_we is never 1 while wb_valid = 0.
- bus_ack outside BUS is ignored.
- A new instruction is never accepted in BUS or WB (in_ready = 0); the upstream must hold its inputs.
- reset asserted in any state: next edge forces all outputs to reset values; an outstanding bus request is dropped without waiting for ack.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to BUS and increments each BUS cycle without ack.
  - If TIMEOUT cycles elapse with no ack: bus_req drops next cycle, state = WB, bus_err pulses 1 for the WB cycle, wb_we = 0, wb_data = 32'hDEAD_BEEF.
  - An ack arriving in the same cycle the counter reaches TIMEOUT wins: normal completion, no error.
- Undefined: no counter; BUS waits indefinitely; bus_err tied 0.

Test Plan:
- Pass-through stream: in_valid = 1 for 4 cycles with in_rd = 1..4, in_rd_val = 0x10..0x13, in_rd_we = 1 -> wb_valid high 4 consecutive cycles, each one cycle after accept, matching rd/data; in_ready stays 1.
- Load with 3 wait states: in_op = 1, in_addr = 0x40, in_rd = 5, ack on 4th BUS cycle with bus_rdata = 0xCAFE0001 -> bus_req high exactly 4 cycles with addr 0x40 and we = 0; wb_valid pulse with rd 5, data 0xCAFE0001; in_ready low from accept until return to IDLE.
- Zero-wait store: in_op = 2, addr 0x80, wdata 0x12345678, ack in first BUS cycle -> bus_req high 1 cycle with we = 1; wb_valid = 1 with wb_we = 0.
- Reset mid-transaction: load issued, reset asserted in 2nd BUS cycle -> bus_req = 0 and in_ready = 1 after that edge; no wb_valid; a later stray ack is ignored.
- Spurious ack in IDLE plus a held input during stall: ack pulses while IDLE -> no output change; a second instruction held during BUS is accepted only on the cycle in_ready returns to 1.
- MEM_TIMEOUT_EN, TIMEOUT = 4: load with no ack -> bus_req high 4 cycles, then bus_err = 1 and wb_data = 0xDEADBEEF with wb_we = 0; repeat with ack on the 4th cycle -> normal completion, bus_err = 0.
